// File: rtl/vec_stream_loader.sv
// ---------------------------------------------------------------------------
// vec_stream_loader
//
// Upstream feeder for the parallel dot-product core. Element pairs (A[i], B[i])
// arrive one per valid/ready handshake and are packed into the flattened
// vec_A_flat / vec_B_flat buses. The loader then pulses the core's start and
// waits for its done. It captures the 32-bit result, presents it on a
// valid/ready result port, and then clears and re-arms for the next vector.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active-low (0 = reset)
//   in_valid     in   element pair valid
//   in_ready     out  loader accepts element pair (high only in FILL)
//   in_a/in_b    in   8-bit unsigned elements A[i], B[i]
//   in_last      in   final element of a short vector (sampled on handshake)
//   vec_A_flat   out  packed A, slot i at [8i+7:8i]
//   vec_B_flat   out  packed B, slot i at [8i+7:8i]
//   core_start   out  one-cycle start pulse to the core
//   core_done    in   core completion (level)
//   core_result  in   core dot-product result
//   res_valid    out  result available
//   res_ready    in   consumer accepts result
//   res_data     out  captured result
//   res_count    out  elements loaded for this result (1..VECTOR_SIZE)
//   state_debug  out  FSM state (FILL=00, START=01, WAIT=10, OUT=11)
//
// Optional build macro VEC_LOADER_STATS_EN adds:
//   stall_cycles out  saturating count of cycles with in_valid=1 & in_ready=0
//   vectors_done out  wrapping count of result handshakes
// ---------------------------------------------------------------------------
module vec_stream_loader #(
  parameter int VECTOR_SIZE = 1024,
  parameter int CNT_W       = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_a,
  input  logic [7:0]               in_b,
  input  logic                     in_last,
  output logic [8*VECTOR_SIZE-1:0] vec_A_flat,
  output logic [8*VECTOR_SIZE-1:0] vec_B_flat,
  output logic                     core_start,
  input  logic                     core_done,
  input  logic [31:0]              core_result,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [31:0]              res_data,
  output logic [CNT_W-1:0]         res_count,
`ifdef VEC_LOADER_STATS_EN
  output logic [31:0]              stall_cycles,
  output logic [15:0]              vectors_done,
`endif
  output logic [1:0]               state_debug
);

  // Slot-select width: enough bits to address VECTOR_SIZE storage slots.
  localparam int IDX_W = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VECTOR_SIZE - 1);

  typedef enum logic [1:0] {
    S_FILL  = 2'b00,
    S_START = 2'b01,
    S_WAIT  = 2'b10,
    S_OUT   = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             wait_armed_q;
  logic             core_start_q;
  logic             res_valid_q;
  logic [31:0]      res_data_q, res_data_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;

  // Element storage; the flats are wired straight from these registers.
  logic [7:0] a_q [VECTOR_SIZE];
  logic [7:0] b_q [VECTOR_SIZE];

  logic             in_ready_s;
  logic             load_s;
  logic             last_s;
  logic             capture_s;
  logic             accept_s;
  logic [IDX_W-1:0] slot_sel_s;

  assign in_ready_s = (state_q == S_FILL);
  assign load_s     = in_valid & in_ready_s;
  // Either an explicit in_last or the final slot closes the vector.
  assign last_s     = load_s & (in_last | (idx_q == LAST_IDX));
  // wait_armed_q masks the first WAIT cycle so a stale done from the previous
  // run cannot be mistaken for completion of this one.
  assign capture_s  = (state_q == S_WAIT) & wait_armed_q & core_done;
  assign accept_s   = (state_q == S_OUT) & res_ready;
  assign slot_sel_s = idx_q[IDX_W-1:0];

  // Next-state logic of the control FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL: begin
        if (last_s) begin
          state_d = S_START;
        end else begin
          state_d = S_FILL;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (capture_s) begin
          state_d = S_OUT;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_OUT: begin
        if (accept_s) begin
          state_d = S_FILL;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  // Next values for element index, result count and result data.
  always_comb begin
    idx_d       = idx_q;
    res_count_d = res_count_q;
    res_data_d  = res_data_q;

    if (accept_s) begin
      idx_d = '0;
    end else if (load_s) begin
      idx_d = idx_q + CNT_W'(1);
    end else begin
      idx_d = idx_q;
    end

    if (last_s) begin
      res_count_d = idx_q + CNT_W'(1);
    end else begin
      res_count_d = res_count_q;
    end

    if (capture_s) begin
      res_data_d = core_result;
    end else begin
      res_data_d = res_data_q;
    end
  end

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_FILL;
      idx_q        <= '0;
      wait_armed_q <= 1'b0;
      core_start_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= 32'd0;
      res_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      // High from the second WAIT cycle onward.
      wait_armed_q <= (state_q == S_WAIT);
      // Registered so the pulse coincides exactly with the START state.
      core_start_q <= (state_d == S_START);
      res_valid_q  <= (state_d == S_OUT);
      res_data_q   <= res_data_d;
      res_count_q  <= res_count_d;
    end
  end

  // Element storage: zeroed on reset and on result accept, written on handshake.
  // Unwritten slots stay zero, which pads short vectors for the core.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        a_q[i] <= 8'd0;
        b_q[i] <= 8'd0;
      end
    end else if (accept_s) begin
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        a_q[i] <= 8'd0;
        b_q[i] <= 8'd0;
      end
    end else if (load_s) begin
      a_q[slot_sel_s] <= in_a;
      b_q[slot_sel_s] <= in_b;
    end
  end

  // Flatten storage onto the core buses; slot i occupies bits [8i+7:8i].
  for (genvar g = 0; g < VECTOR_SIZE; g++) begin : g_flat
    assign vec_A_flat[g*8 +: 8] = a_q[g];
    assign vec_B_flat[g*8 +: 8] = b_q[g];
  end

  assign in_ready    = in_ready_s;
  assign core_start  = core_start_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_count   = res_count_q;
  assign state_debug = state_q;

`ifdef VEC_LOADER_STATS_EN
  localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

  logic [31:0] stall_q, stall_d;
  logic [15:0] vdone_q, vdone_d;

  // Next values for the statistics counters.
  always_comb begin
    stall_d = stall_q;
    vdone_d = vdone_q;
    if (in_valid && !in_ready_s && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
    if (accept_s) begin
      vdone_d = vdone_q + 16'd1;
    end else begin
      vdone_d = vdone_q;
    end
  end

  // Statistics registers, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= 32'd0;
      vdone_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
      vdone_q <= vdone_d;
    end
  end

  assign stall_cycles = stall_q;
  assign vectors_done = vdone_q;
`endif

endmodule

// File: tb/tb_vec_stream_loader.sv
module tb_vec_stream_loader;

  localparam int VS = 1024;
  localparam int CW = 11;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      in_a;
  logic [7:0]      in_b;
  logic            in_last;
  logic [8*VS-1:0] vec_A_flat;
  logic [8*VS-1:0] vec_B_flat;
  logic            core_start;
  logic            core_done;
  logic [31:0]     core_result;
  logic            res_valid;
  logic            res_ready;
  logic [31:0]     res_data;
  logic [CW-1:0]   res_count;
  logic [1:0]      state_debug;
`ifdef VEC_LOADER_STATS_EN
  logic [31:0]     stall_cycles;
  logic [15:0]     vectors_done;
`endif

  vec_stream_loader #(.VECTOR_SIZE(VS), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .vec_A_flat(vec_A_flat), .vec_B_flat(vec_B_flat),
    .core_start(core_start), .core_done(core_done), .core_result(core_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_count(res_count),
`ifdef VEC_LOADER_STATS_EN
    .stall_cycles(stall_cycles), .vectors_done(vectors_done),
`endif
    .state_debug(state_debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- core behavioural model ----------------
  logic stale_mode = 1'b0;
  logic stale_pend = 1'b0;
  int   mdl_cnt = 0;
  int   start_pulses = 0;

  function automatic logic [31:0] dot(input logic [8*VS-1:0] a, input logic [8*VS-1:0] b);
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < VS; i++) s = s + 32'(a[i*8 +: 8]) * 32'(b[i*8 +: 8]);
    return s;
  endfunction

  // Core model: clears done on start, reports result two cycles later.
  // In stale mode it keeps done=1 with a bogus result for one cycle first.
  always @(posedge clk) begin
    if (!rst) begin
      core_done   <= 1'b0;
      core_result <= 32'd0;
      mdl_cnt     <= 0;
      stale_pend  <= 1'b0;
    end else if (core_start) begin
      start_pulses <= start_pulses + 1;
      if (stale_mode) begin
        core_done   <= 1'b1;
        core_result <= 32'd999;
        stale_pend  <= 1'b1;
      end else begin
        core_done <= 1'b0;
        mdl_cnt   <= 2;
      end
    end else if (stale_pend) begin
      core_done   <= 1'b1;
      core_result <= 32'd42;
      stale_pend  <= 1'b0;
    end else if (mdl_cnt == 1) begin
      core_done   <= 1'b1;
      core_result <= dot(vec_A_flat, vec_B_flat);
      mdl_cnt     <= 0;
    end else if (mdl_cnt > 1) begin
      mdl_cnt <= mdl_cnt - 1;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out, got no event expected one", name);
  endtask

  // Called at a negedge; presents one pair and returns at the negedge after acceptance.
  task automatic send_elem(input logic [7:0] a, input logic [7:0] b, input logic last);
    int g;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) timeout_fail("send_wait");
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_result();
    int g;
    g = 0;
    while (!res_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) timeout_fail("result_wait");
  endtask

  task automatic do_accept();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("acc_res_valid", {31'd0, res_valid}, 32'd0);
    check("acc_flats_zero", {31'd0, (vec_A_flat == '0) && (vec_B_flat == '0)}, 32'd1);
    check("acc_state_fill", {30'd0, state_debug}, 32'd0);
  endtask

  typedef struct {
    int          len;
    logic [7:0]  a0, da, b0, db;
    logic        use_last;
    int          hold;
    logic [31:0] exp_data;
    logic [31:0] exp_count;
  } vec_t;

  vec_t tbl [7];

  initial begin : main
    logic [7:0] ea, eb;
    int         base;
    logic       flat_ok;

    tbl[0] = '{8,    8'd1,   8'd1, 8'd1,   8'd1,   1'b1, 5, 32'd204,      32'd8};
    tbl[1] = '{1024, 8'd255, 8'd0, 8'd255, 8'd0,   1'b0, 0, 32'd66585600, 32'd1024};
    tbl[2] = '{4,    8'd1,   8'd1, 8'd1,   8'd0,   1'b1, 1, 32'd10,       32'd4};
    tbl[3] = '{1,    8'd7,   8'd0, 8'd9,   8'd0,   1'b1, 2, 32'd63,       32'd1};
    tbl[4] = '{1024, 8'd1,   8'd0, 8'd2,   8'd0,   1'b1, 0, 32'd2048,     32'd1024};
    tbl[5] = '{3,    8'd10,  8'd10, 8'd3,  8'hFF,  1'b1, 3, 32'd100,      32'd3};
    tbl[6] = '{1024, 8'd0,   8'd1, 8'd1,   8'd0,   1'b0, 0, 32'd130560,   32'd1024};

    rst = 1'b0; in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0; in_last = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_state", {30'd0, state_debug}, 32'd0);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_count", 32'(res_count), 32'd0);
    check("rst_core_start", {31'd0, core_start}, 32'd0);
    check("rst_flats_zero", {31'd0, (vec_A_flat == '0) && (vec_B_flat == '0)}, 32'd1);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b1;
    @(negedge clk);

    // Table-driven vectors
    for (int t = 0; t < 7; t++) begin
      base = start_pulses;
      for (int i = 0; i < tbl[t].len; i++) begin
        ea = tbl[t].a0 + 8'(i) * tbl[t].da;
        eb = tbl[t].b0 + 8'(i) * tbl[t].db;
        send_elem(ea, eb, tbl[t].use_last && (i == tbl[t].len - 1));
      end
      check("start_pulse_hi", {31'd0, core_start}, 32'd1);
      check("state_start", {30'd0, state_debug}, 32'd1);
      @(negedge clk);
      check("start_pulse_lo", {31'd0, core_start}, 32'd0);
      check("state_wait", {30'd0, state_debug}, 32'd2);
      wait_result();
      check("res_data", res_data, tbl[t].exp_data);
      check("res_count", 32'(res_count), tbl[t].exp_count);
      check("start_count", 32'(start_pulses - base), 32'd1);
      flat_ok = 1'b1;
      for (int i = 0; i < VS; i++) begin
        ea = (i < tbl[t].len) ? tbl[t].a0 + 8'(i) * tbl[t].da : 8'd0;
        eb = (i < tbl[t].len) ? tbl[t].b0 + 8'(i) * tbl[t].db : 8'd0;
        if (vec_A_flat[i*8 +: 8] !== ea || vec_B_flat[i*8 +: 8] !== eb) flat_ok = 1'b0;
      end
      check("flat_content", {31'd0, flat_ok}, 32'd1);
      for (int k = 0; k < tbl[t].hold; k++) begin
        @(negedge clk);
        check("hold_valid", {31'd0, res_valid}, 32'd1);
        check("hold_data", res_data, tbl[t].exp_data);
        check("hold_count", 32'(res_count), tbl[t].exp_count);
      end
      do_accept();
    end

    // Backpressure: keep in_valid high through START/WAIT/OUT
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_elem(8'd2, 8'd5, 1'b0);
    send_elem(8'd3, 8'd5, 1'b0);
    send_elem(8'd4, 8'd5, 1'b1);
    in_a = 8'h55; in_b = 8'h66; in_valid = 1'b1; in_last = 1'b0;
    wait_result();
    check("bp_in_ready_lo", {31'd0, in_ready}, 32'd0);
    check("bp_slot0_kept", 32'(vec_A_flat[7:0]), 32'd2);
    check("bp_slot3_clean", 32'(vec_A_flat[31:24]), 32'd0);
    repeat (2) @(negedge clk);
    check("bp_res_data", res_data, 32'd45);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("bp_res_valid_lo", {31'd0, res_valid}, 32'd0);
    check("bp_in_ready_gap", {31'd0, in_ready}, 32'd1);
    check("bp_flats_zero", {31'd0, (vec_A_flat == '0) && (vec_B_flat == '0)}, 32'd1);
    @(negedge clk);
    check("bp_slot0_a", 32'(vec_A_flat[7:0]), 32'h55);
    check("bp_slot0_b", 32'(vec_B_flat[7:0]), 32'h66);
`ifdef VEC_LOADER_STATS_EN
    check("bp_stall_cycles", stall_cycles, 32'd7);
    check("bp_vectors_done", 32'(vectors_done), 32'd1);
`endif
    send_elem(8'd1, 8'd1, 1'b1);
    wait_result();
    check("bp2_res_data", res_data, 32'd8671);
    check("bp2_res_count", 32'(res_count), 32'd2);
    do_accept();

    // Reset mid-fill
    for (int i = 0; i < 10; i++) send_elem(8'(i + 1), 8'd3, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mid_rst_flats", {31'd0, (vec_A_flat == '0) && (vec_B_flat == '0)}, 32'd1);
    check("mid_rst_state", {30'd0, state_debug}, 32'd0);
    check("mid_rst_valid", {31'd0, res_valid}, 32'd0);
    for (int i = 0; i < 4; i++) send_elem(8'(i + 1), 8'd1, i == 3);
    wait_result();
    check("mid_rst_data", res_data, 32'd10);
    check("mid_rst_count", 32'(res_count), 32'd4);
    do_accept();

    // Stale done from the core on the first WAIT cycle
    stale_mode = 1'b1;
    send_elem(8'd6, 8'd7, 1'b1);
    wait_result();
    check("stale_data", res_data, 32'd42);
    check("stale_count", 32'(res_count), 32'd1);
    do_accept();
    stale_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vec_stream_loader.md
Name: vec_stream_loader

Overview:
- Upstream feeder for the parallel dot-product core (Parallel_Vector).
- Accepts element pairs (A[i], B[i]) one per handshake, packs them into the flattened vec_A_flat/vec_B_flat buses, and pulses the core's start.
- Waits for the core's done, captures the 32-bit result, and presents it on a valid/ready result port. Then it clears and re-arms for the next vector.

Parameters:
- VECTOR_SIZE, 1024, element slots per vector (1..1024); must match the core.
- CNT_W, 11, width of element index/count; must be at least clog2(VECTOR_SIZE+1).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-low (0 = reset)
- in_valid  in  1  element pair valid
- in_ready  out  1  loader accepts element pair
- in_a  in  8  element A[i], unsigned
- in_b  in  8  element B[i], unsigned
- in_last  in  1  marks final element of a short vector; sampled only on handshake
- vec_A_flat  out  8*VECTOR_SIZE  packed A; slot i at [8i+7:8i]
- vec_B_flat  out  8*VECTOR_SIZE  packed B
- core_start  out  1  one-cycle start pulse to core
- core_done  in  1  core completion (level)
- core_result  in  32  core dot-product result
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  32  captured result
- res_count  out  CNT_W  elements loaded for this result (1..VECTOR_SIZE)
- state_debug  out  2  FSM state

Behaviour:
- Reset (rst=0 at clk edge) values: state=FILL, idx=0, both flats=0, core_start=0, res_valid=0, res_data=0, res_count=0. Reset mid-operation aborts everything, including a core run in progress; core_done/core_result are ignored until the next START.
- FSM encoding: FILL=2'b00, START=2'b01, WAIT=2'b10, OUT=2'b11. in_ready=1 only in FILL (combinational from state).
- FILL: a handshake (in_valid & in_ready) writes in_a/in_b to slot idx and increments idx.
  - Go to START if in_last=1 or idx==VECTOR_SIZE-1 on that handshake. Latch res_count=idx+1 at that point.
  - in_last on the VECTOR_SIZE-th element behaves the same as a full vector.
  - Slots not written remain zero (zero-padding), so a short vector yields the correct dot product.
- START: core_start=1 for exactly this one cycle; the flats are stable. The next state is WAIT.
- WAIT: core_done is ignored on the first WAIT cycle, which covers the core clearing a stale done. From the second cycle on, core_done=1 captures core_result into res_data and moves to OUT. No timeout.
- OUT: res_valid=1. res_data/res_count are held stable while res_ready=0. On res_ready=1:
  - res_valid drops the next cycle.
  - Flats clear to 0 and idx=0.
  - The FSM returns to FILL.
- Latency:
  - Last element accepted at edge N gives core_start high in cycle N+1.
  - core_done seen at edge M gives res_valid high from cycle M+1.
  - Minimum gap from result accept to in_ready high is 1 cycle.
- Flats are registered outputs driven directly from the storage registers. There is no extra copy stage.
- in_valid while in_ready=0 is legal. The data is not consumed, and the source must hold it.

Optional Feature:
- Macro: VEC_LOADER_STATS_EN.
- Defined:
  - Adds output stall_cycles [31:0], which counts cycles with in_valid=1 & in_ready=0. It saturates at 32'hFFFFFFFF and clears only on reset.
  - Adds output vectors_done [15:0], which increments on each result handshake and wraps.
- Undefined: neither port nor its counters exist. Core behaviour is identical.

Test Plan:
- Full vector, VECTOR_SIZE=1024, all A=B=255, loader driving a real Parallel_Vector (NUM_MACS=64) -> one core_start pulse, res_data=66585600, res_count=1024.
- Short vector: A=B=1..8 with in_last on the 8th element -> res_data=204, res_count=8, slots 8..1023 of both flats read 0.
- Backpressure: hold in_valid=1 through START/WAIT/OUT -> in_ready=0, no slot changes, next element lands in slot 0 after the result handshake. With the macro defined, stall_cycles equals the stalled cycle count.
- Result hold: res_ready=0 for 5 cycles after res_valid -> res_data/res_count constant. Then res_ready=1 -> res_valid=0 the next cycle and flats cleared.
- Reset mid-fill: load 10 elements, pull rst low for 1 cycle -> flats=0, state_debug=00, res_valid=0. Then a fresh 4-element vector (1,2,3,4)·(1,1,1,1) -> res_data=10.
- Stale done: core model holds core_done=1 into the first WAIT cycle with core_result=999, then gives done=1 and result=42 on the second cycle -> res_data=42.
